// File: rtl/aoc_pkg.sv
// Shared types and constants for the report sequencer and its solver-facing bus.
package aoc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    GAP,
    DRAIN,
    DONE,
    ERR
  } seq_state_t;

  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam int         CNT_W = 16;

endpackage

// File: rtl/report_sequencer_if.sv
// ROM read port plus byte stream / result handshake between sequencer and solver.
interface report_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic                      rom_rd;
  logic [ADDR_W-1:0]         rom_addr;
  logic [7:0]                rom_data;
  logic [7:0]                byte_out;
  logic                      byte_out_valid;
  logic                      bytes_done;
  logic                      nums_valid;
  logic [aoc_pkg::CNT_W-1:0] num_safe;
  logic [aoc_pkg::CNT_W-1:0] num_unsafe;

  modport master (
    output rom_rd, rom_addr, byte_out, byte_out_valid, bytes_done,
    input  rom_data, nums_valid, num_safe, num_unsafe
  );

  modport slave (
    input  rom_rd, rom_addr, byte_out, byte_out_valid, bytes_done,
    output rom_data, nums_valid, num_safe, num_unsafe
  );
endinterface

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expired is raised while enabled and the count has reached zero.
module seq_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expired = en && (cnt == '0);
endmodule

// File: rtl/report_sequencer.sv
// Streams a byte ROM to the report solver, one byte per two cycles, pausing after newlines,
// then holds end-of-stream until the solver reports or the drain watchdog fires.
module report_sequencer
  import aoc_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int LINE_GAP = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    byte_count,
  report_sequencer_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   safe_count,
  output logic [CNT_W-1:0]   unsafe_count,
  output logic [CNT_W-1:0]   line_count
);
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  seq_state_t       state, state_nx;
  logic [ADDR_W:0]  addr, addr_nx, count;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             last, is_nl, launch, wd_load, wd_expired;

  // addr/count carry one extra bit so a full 2^ADDR_W byte ROM never wraps
  assign last   = (addr == count - ONE);
  assign is_nl  = (bus.rom_data == CH_NL);
  assign launch = start && (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    gap_nx   = gap_cnt;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) state_nx = (byte_count == '0) ? DRAIN : FETCH;
      FETCH:
        state_nx = PRESENT;
      PRESENT:
        if (is_nl && LINE_GAP > 0) begin
          state_nx = GAP;
          gap_nx   = GAP_W'(LINE_GAP - 1);
        end else if (last) begin
          state_nx = DRAIN;
        end else begin
          state_nx = FETCH;
          addr_nx  = addr + ONE;
        end
      GAP:
        if (gap_cnt != '0) begin
          gap_nx = gap_cnt - GAP_W'(1);
        end else if (last) begin
          state_nx = DRAIN;
        end else begin
          state_nx = FETCH;
          addr_nx  = addr + ONE;
        end
      DRAIN:
        // a result arriving on the expiry cycle still counts as success
        if (bus.nums_valid)  state_nx = DONE;
        else if (wd_expired) state_nx = ERR;
      default:
        state_nx = IDLE;
    endcase
  end

  assign wd_load = (state_nx == DRAIN) && (state != DRAIN);

  seq_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT - 1)),
    .en       (state == DRAIN),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      count        <= '0;
      gap_cnt      <= '0;
      line_count   <= '0;
      safe_count   <= '0;
      unsafe_count <= '0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      gap_cnt <= gap_nx;
      if (launch) begin
        addr       <= '0;
        count      <= byte_count;
        line_count <= '0;
      end
      if (state == PRESENT && is_nl && line_count != {CNT_W{1'b1}})
        line_count <= line_count + CNT_W'(1);
      if (state == DRAIN && bus.nums_valid) begin
        safe_count   <= bus.num_safe;
        unsafe_count <= bus.num_unsafe;
      end
    end
  end

  assign bus.rom_rd         = (state == FETCH);
  assign bus.rom_addr       = (state == FETCH) ? addr[ADDR_W-1:0] : '0;
  assign bus.byte_out       = (state == PRESENT) ? bus.rom_data : 8'h00;
  assign bus.byte_out_valid = (state == PRESENT);
  // held through DONE so the solver stays frozen on its final counts
  assign bus.bytes_done     = (state == DRAIN) || (state == DONE);
  assign busy               = (state == FETCH) || (state == PRESENT) ||
                              (state == GAP)   || (state == DRAIN);
  assign done               = (state == DONE);
  assign timeout            = (state == ERR);
endmodule

// File: tb/tb_report_sequencer.sv
// Directed bench: ROM model plus a behavioural report solver (with single-level dampener) or stubs.
module tb_report_sequencer;
  import aoc_pkg::*;

  localparam int AW = 8;
  localparam int LG = 3;
  localparam int TO = 20;

  logic              clk, rst, start;
  logic [AW:0]       byte_count;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  safe_count, unsafe_count, line_count;

  report_sequencer_if #(.ADDR_W(AW)) bus ();

  report_sequencer #(.ADDR_W(AW), .LINE_GAP(LG), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_count   (byte_count),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .safe_count   (safe_count),
    .unsafe_count (unsafe_count),
    .line_count   (line_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ROM: data valid one cycle after the read strobe
  logic [7:0] rom [0:255];
  always @(posedge clk) begin
    if (rst)             bus.rom_data <= 8'h00;
    else if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
  end

  // Solver: mode 0 real, mode 1 stub answering 2 cycles into drain, mode 2 silent
  int   sol_mode;
  logic sol_clr;
  int   stub_safe, stub_unsafe;
  int   sol_nums[$];
  int   sol_cur, sol_s, sol_u, sol_stub_n;
  bit   sol_have;

  function automatic bit lvl_ok(input int v[$]);
    bit up;
    int d;
    if (v.size() < 2) return 1'b1;
    up = v[1] > v[0];
    for (int i = 1; i < v.size(); i++) begin
      d = up ? v[i] - v[i-1] : v[i-1] - v[i];
      if (d < 1 || d > 3) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit damp_ok(input int v[$]);
    int w[$];
    if (lvl_ok(v)) return 1'b1;
    for (int k = 0; k < v.size(); k++) begin
      w = v;
      w.delete(k);
      if (lvl_ok(w)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task close_line();
    if (sol_have) sol_nums.push_back(sol_cur);
    sol_cur = 0;
    sol_have = 0;
    if (sol_nums.size() > 0) begin
      if (damp_ok(sol_nums)) sol_s++; else sol_u++;
      sol_nums.delete();
    end
  endtask

  always @(posedge clk) begin
    if (rst || sol_clr) begin
      sol_nums.delete();
      sol_cur = 0; sol_have = 0; sol_s = 0; sol_u = 0; sol_stub_n = 0;
      bus.nums_valid <= 1'b0;
      bus.num_safe   <= '0;
      bus.num_unsafe <= '0;
    end else if (sol_mode == 0) begin
      if (bus.byte_out_valid) begin
        if (bus.byte_out >= 8'h30 && bus.byte_out <= 8'h39) begin
          sol_cur  = sol_cur * 10 + int'(bus.byte_out - 8'h30);
          sol_have = 1;
        end else if (bus.byte_out == CH_NL) begin
          close_line();
        end else if (bus.byte_out == CH_SP) begin
          if (sol_have) sol_nums.push_back(sol_cur);
          sol_cur = 0; sol_have = 0;
        end
      end else if (bus.bytes_done && !bus.nums_valid) begin
        close_line();
        bus.nums_valid <= 1'b1;
        bus.num_safe   <= CNT_W'(sol_s);
        bus.num_unsafe <= CNT_W'(sol_u);
      end
    end else if (sol_mode == 1) begin
      if (bus.bytes_done) begin
        sol_stub_n++;
        if (sol_stub_n == 2) begin
          bus.nums_valid <= 1'b1;
          bus.num_safe   <= CNT_W'(stub_safe);
          bus.num_unsafe <= CNT_W'(stub_unsafe);
        end
      end
    end
  end

  // Monitor, sampled just after each rising edge
  int         cyc = 0;
  int         pv_cyc[$];
  logic [7:0] pv_byte[$];
  int         rd_n, bd_rise, to_rise;
  logic       bd_q = 1'b0, to_q = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.byte_out_valid) begin
      pv_cyc.push_back(cyc);
      pv_byte.push_back(bus.byte_out);
    end
    if (bus.rom_rd) rd_n++;
    if (bus.bytes_done && !bd_q) bd_rise = cyc;
    if (timeout && !to_q) to_rise = cyc;
    bd_q = bus.bytes_done;
    to_q = timeout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rom_rd"},         32'(bus.rom_rd), 0);
    chk({tag, " rom_addr"},       32'(bus.rom_addr), 0);
    chk({tag, " byte_out"},       32'(bus.byte_out), 0);
    chk({tag, " byte_out_valid"}, 32'(bus.byte_out_valid), 0);
    chk({tag, " bytes_done"},     32'(bus.bytes_done), 0);
    chk({tag, " busy"},           32'(busy), 0);
    chk({tag, " done"},           32'(done), 0);
    chk({tag, " timeout"},        32'(timeout), 0);
    chk({tag, " safe_count"},     32'(safe_count), 0);
    chk({tag, " unsafe_count"},   32'(unsafe_count), 0);
    chk({tag, " line_count"},     32'(line_count), 0);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic launch(input int n, input int mode);
    @(negedge clk);
    sol_mode = mode;
    pv_cyc.delete();
    pv_byte.delete();
    rd_n = 0; bd_rise = -1; to_rise = -1;
    byte_count = (AW+1)'(n);
    start = 1'b1;
    sol_clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sol_clr = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || timeout) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " finished in budget"}, 32'(n < 2000), 1);
  endtask

  task automatic wait_pulses(input string tag, input int k);
    int n = 0;
    while (pv_cyc.size() < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " reached pulse"}, 32'(n < 500), 1);
  endtask

  // Pulse spacing: 2 cycles, or 2+LINE_GAP after a newline byte
  function automatic int bad_spacing();
    int bad = 0;
    for (int i = 1; i < pv_cyc.size(); i++)
      if (pv_cyc[i] - pv_cyc[i-1] != ((pv_byte[i-1] == CH_NL) ? 2 + LG : 2)) bad++;
    return bad;
  endfunction

  function automatic int rom_mismatch();
    int bad = 0;
    for (int i = 0; i < pv_byte.size(); i++)
      if (pv_byte[i] !== rom[i]) bad++;
    return bad;
  endfunction

  localparam string EXAMPLE =
    "7 6 4 2 1\n1 2 7 8 9\n9 7 6 2 1\n1 3 2 4 5\n8 6 4 4 1\n1 3 6 7 9\n";

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rst = 1'b1; start = 1'b0; byte_count = '0;
    sol_clr = 1'b0; sol_mode = 2; stub_safe = 0; stub_unsafe = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Day-2 example, 60 bytes with trailing newline
    load_str(EXAMPLE);
    launch(60, 0);
    chk("ex busy", 32'(busy), 1);
    wait_end("ex");
    chk("ex done", 32'(done), 1);
    chk("ex timeout", 32'(timeout), 0);
    chk("ex safe", 32'(safe_count), 4);
    chk("ex unsafe", 32'(unsafe_count), 2);
    chk("ex lines", 32'(line_count), 6);
    chk("ex pulses", 32'(pv_cyc.size()), 60);
    chk("ex nl gap", 32'(pv_cyc[10] - pv_cyc[9]), 2 + LG);
    chk("ex spacing errors", 32'(bad_spacing()), 0);
    chk("ex bytes_done held", 32'(bus.bytes_done), 1);

    // start while busy is ignored and does not restart addressing
    launch(60, 0);
    wait_pulses("busy", 12);
    @(negedge clk);
    byte_count = (AW+1)'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy still busy", 32'(busy), 1);
    wait_end("busy");
    chk("busy pulses", 32'(pv_cyc.size()), 60);
    chk("busy byte order", 32'(rom_mismatch()), 0);
    chk("busy safe", 32'(safe_count), 4);
    chk("busy unsafe", 32'(unsafe_count), 2);
    chk("busy lines", 32'(line_count), 6);

    // "1 2 3" without trailing newline
    load_str("1 2 3");
    launch(5, 0);
    wait_end("nonl");
    chk("nonl pulses", 32'(pv_cyc.size()), 5);
    chk("nonl spacing errors", 32'(bad_spacing()), 0);
    chk("nonl bytes_done rise", 32'(bd_rise), 32'(pv_cyc[4] + 1));
    chk("nonl safe", 32'(safe_count), 1);
    chk("nonl unsafe", 32'(unsafe_count), 0);
    chk("nonl lines", 32'(line_count), 0);

    // empty input, stub solver
    stub_safe = 7; stub_unsafe = 9;
    launch(0, 1);
    wait_end("empty");
    chk("empty rom_rd count", 32'(rd_n), 0);
    chk("empty done", 32'(done), 1);
    chk("empty safe", 32'(safe_count), 7);
    chk("empty unsafe", 32'(unsafe_count), 9);

    // silent solver: watchdog expiry
    launch(5, 2);
    wait_end("wd");
    chk("wd timeout", 32'(timeout), 1);
    chk("wd done", 32'(done), 0);
    chk("wd delay", 32'(to_rise - bd_rise), TO);
    chk("wd safe kept", 32'(safe_count), 7);
    chk("wd unsafe kept", 32'(unsafe_count), 9);
    chk("wd busy", 32'(busy), 0);

    // reset during the 10th byte, then a clean rerun
    load_str(EXAMPLE);
    launch(60, 0);
    wait_pulses("rst", 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    repeat (6) @(negedge clk);
    chk("midrst no more pulses", 32'(pv_cyc.size()), 10);
    launch(60, 0);
    wait_end("rerun");
    chk("rerun done", 32'(done), 1);
    chk("rerun safe", 32'(safe_count), 4);
    chk("rerun unsafe", 32'(unsafe_count), 2);
    chk("rerun lines", 32'(line_count), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/report_sequencer.md
REPORT_SEQUENCER -- requirements
Module: report_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16: byte-ROM address width; max input length 2^ADDR_W bytes.
REQ-002 Parameter LINE_GAP, default 3: idle cycles inserted after every newline byte.
REQ-003 Parameter TIMEOUT, default 64: drain cycles allowed before timeout.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that launches a run.
REQ-007 byte_count  in  ADDR_W+1  number of input bytes; sampled on the start cycle.
REQ-008 rom_rd  out  1  ROM read strobe.
REQ-009 rom_addr  out  ADDR_W  ROM read address.
REQ-010 rom_data  in  8  ROM data, valid exactly one cycle after rom_rd.
REQ-011 byte_out  out  8  byte presented to the report solver.
REQ-012 byte_out_valid  out  1  byte_out qualifier, one-cycle pulse per byte.
REQ-013 bytes_done  out  1  end-of-stream level to the solver.
REQ-014 nums_valid  in  1  solver final-result flag.
REQ-015 num_safe, num_unsafe  in  16 each  solver counters.
REQ-016 busy, done, timeout  out  1 each  run status.
REQ-017 safe_count, unsafe_count  out  16 each  latched results.
REQ-018 line_count  out  16  newlines streamed in the current run.

Function
REQ-019 FSM states: IDLE, FETCH, PRESENT, GAP, DRAIN, DONE, ERR.
REQ-020 IDLE -> FETCH on start; addr <= 0; count latched; line_count, done, timeout cleared. If byte_count == 0, IDLE -> DRAIN instead.
REQ-021 FETCH: rom_rd = 1, rom_addr = addr, for one cycle; next state PRESENT.
REQ-022 PRESENT: byte_out = rom_data and byte_out_valid = 1 for one cycle; throughput is one byte per 2 cycles.
REQ-023 PRESENT exit, by priority:
- byte == 8'h0A -> GAP; line_count increments.
- else if addr == count-1 -> DRAIN.
- else -> FETCH with addr+1.
REQ-024 GAP: byte_out_valid = 0 for exactly LINE_GAP cycles. Then DRAIN if addr == count-1, else FETCH with addr+1.
REQ-025 DRAIN: bytes_done = 1 held every cycle; byte_out_valid = 0. Watchdog counts drain cycles.
REQ-026 DRAIN exits:
- nums_valid = 1 -> DONE; safe_count/unsafe_count latch num_safe/num_unsafe.
- watchdog reaches TIMEOUT with no nums_valid -> ERR.
- nums_valid wins if both occur in the same cycle.
REQ-027 DONE: done = 1 as a level; bytes_done is held at 1 so the solver stays frozen. start -> new run per REQ-020.
REQ-028 ERR: timeout = 1 as a level; counts are not updated. start -> new run.
REQ-029 busy = 1 in FETCH, PRESENT, GAP and DRAIN; start while busy is ignored.
REQ-030 nums_valid seen outside DRAIN is ignored.
REQ-031 addr and count are ADDR_W+1 wide, so byte_count = 2^ADDR_W never wraps.
REQ-032 line_count saturates at 16'hFFFF.
REQ-033 A final line without a trailing newline is legal; bytes_done terminates it.

Reset
REQ-034 rst forces IDLE. All outputs return 0: rom_rd, rom_addr, byte_out, byte_out_valid, bytes_done, busy, done, timeout, safe_count, unsafe_count, line_count.
REQ-035 rst mid-run aborts the run on the next edge with no further byte_out_valid pulses. The solver must be reset in the same cycle by the parent.

Structure
REQ-036 Shared package aoc_pkg holds:
- state enum seq_state_t;
- ASCII constants CH_NL = 8'h0A, CH_SP = 8'h20;
- result width localparam CNT_W = 16.
REQ-037 One sub-module, seq_watchdog: a loadable down-counter with an expiry flag, used in DRAIN.

Verification
REQ-038 AoC day-2 example:
- Stimulus: 6 reports, 60 bytes, trailing newline, solver attached.
- Required: done; safe_count = 4; unsafe_count = 2; line_count = 6.
REQ-039 ROM "1 2 3" with no newline, byte_count = 5:
- Required: 5 valid pulses, each 2 cycles apart.
- Required: bytes_done asserted the cycle after the last PRESENT.
- Required: safe_count = 1; unsafe_count = 0.
REQ-040 byte_count = 0 with a stub that raises nums_valid after 2 cycles:
- Required: no rom_rd.
- Required: DONE with stub counts, e.g. num_safe = 7 gives safe_count = 7.
REQ-041 Stub that never raises nums_valid:
- Required: timeout = 1 exactly TIMEOUT cycles after bytes_done rises.
- Required: done = 0; counts unchanged.
REQ-042 rst at the 10th byte, then start again:
- Required: all outputs 0 the cycle after rst.
- Required: the second run reproduces the REQ-038 results.
REQ-043 Newline timing and start-while-busy:
- Required: exactly LINE_GAP = 3 idle cycles after each 0x0A.
- Required: start pulsed while busy is ignored, with no addr reset.
